quotient_calc: RTL and testbench
================================

# quotient_calc

Sequential radix-2 restoring mantissa divider for the FPU divide path; the inverse counterpart of the mantissa product stage. Takes two 24-bit significands (hidden bit included), produces a 27-bit fixed-point quotient (1 integer bit, 26 fraction bits) plus a sticky bit for downstream rounding. Uses the same level handshake as the product stage (`in_ready`/`out_ready`) and sits between exponent subtraction and normalise/round.

## Interface
- `MW`, 24: mantissa width, hidden bit included.
- `QW`, `MW+3` (27): quotient width, 1 integer bit and `MW+2` fraction bits. Derived; not overridden.

- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_ready`  in  1: operands valid; level, held until `out_ready` is seen.
- `a_m`  in  MW: dividend significand.
- `b_m`  in  MW: divisor significand.
- `out_ready`  out  1: result valid.
- `quotient_out`  out  QW: floor(a_m·2^(QW-1) / b_m), or saturated.
- `sticky_out`  out  1: remainder non-zero.
- `dz_out`  out  1: `b_m == 0`.
- `ovf_out`  out  1: precondition `a_m < 2·b_m` violated.

## Operation
- States: IDLE, DIVIDE, DONE.
- IDLE: `out_ready` = 0. On `in_ready` = 1:
  - Latch `b_m`.
  - Set remainder (MW+1 bits) = `a_m`.
  - Clear the step counter.
  - If `a_m >= 2·b_m` (includes `b_m` = 0): go to DONE, `quotient_out` = all ones, `sticky_out` = 0, `ovf_out` = 1, `dz_out` = (`b_m` == 0), `out_ready` = 1.
  - Otherwise go to DIVIDE, with `dz_out` = 0 and `ovf_out` = 0.
- DIVIDE: one step per cycle, QW steps, MSB first.
  - If rem >= b: bit = 1, rem -= b; else bit = 0.
  - rem <<= 1. The step before the shift never exceeds MW+1 bits.
  - Shift the bit into the quotient register.
  - On the last step (counter = QW-1):
    - `quotient_out` = final quotient.
    - `sticky_out` = (final rem != 0).
    - `out_ready` = 1.
    - Go to DONE.
- DONE: `out_ready` stays 1 and all outputs hold while `in_ready` = 1. When `in_ready` = 0, go to IDLE and clear `out_ready` on that edge. Result outputs keep their values until the next completion.
- Operand changes while in DIVIDE or DONE are ignored; only the latched values are used.
- Reset values: state IDLE, `out_ready` 0, `quotient_out` 0, `sticky_out` 0, `dz_out` 0, `ovf_out` 0, counter 0.

## Timing
- Capture edge E0 is the first rising edge in IDLE with `in_ready` = 1.
- Normal path: steps on E1..E27; `out_ready` rises at E27. Latency is QW cycles.
- Saturate path: `out_ready` rises at E1.
- `out_ready` falls on the first edge in DONE that samples `in_ready` = 0. The earliest next capture is the following edge.
- Back-to-back requests: a new capture can occur at the earliest two edges after `out_ready` rises, since `in_ready` must drop at least one cycle.
- Asynchronous reset during DIVIDE or DONE aborts immediately. All outputs go to their reset values and no partial result is presented. After release the block waits in IDLE for a fresh `in_ready`.
- `in_ready` already high when reset releases: capture occurs on the first edge after release.

## Structure
- Package `fpu_div_pkg`:
  - `div_state_t` enum (IDLE, DIVIDE, DONE).
  - `MW`/`QW` defaults.
  - Counter width constant `$clog2(QW)`.
- Sub-module `div_step` (combinational): inputs rem[MW:0] and b[MW-1:0]; outputs q_bit and next_rem (already shifted). The top-level FSM is instantiated once around it.
- Counter, quotient shift register and result registers live in the top level.

## Test plan
- `a_m`=0x800000, `b_m`=0x800000 -> after 27 cycles `quotient_out`=0x4000000, `sticky_out`=0, `dz_out`=0, `ovf_out`=0.
- `a_m`=0xC00000, `b_m`=0x800000 -> `quotient_out`=0x6000000, `sticky_out`=0.
- `a_m`=0x800000, `b_m`=0xC00000 -> `quotient_out`=0x2AAAAAA, `sticky_out`=1.
- `a_m`=0xFFFFFF, `b_m`=0x800000 -> `quotient_out`=0x7FFFFF8, `sticky_out`=0.
- `b_m`=0, `a_m`=0x800000 -> `out_ready` at E1, `quotient_out`=0x7FFFFFF, `dz_out`=1, `ovf_out`=1.
- Handshake and reset:
  - Hold `in_ready` high 50 cycles after completion -> exactly one result and no restart; `out_ready` drops one edge after `in_ready` falls.
  - Assert `rst_n` at step 10 -> all outputs 0 immediately; the next request completes correctly.

Source files
------------

// File: rtl/fpu_div_pkg.sv
// Purpose : shared widths and state encoding for the mantissa divide path.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package fpu_div_pkg;

    localparam int MW = 24;            // significand width, hidden bit included
    localparam int QW = MW + 3;        // quotient: 1 integer bit + MW+2 fraction bits
    localparam int CW = $clog2(QW);    // step counter width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } div_state_t;

endpackage

// File: rtl/quotient_calc_if.sv
// Purpose : operand/result bundle of the mantissa divider (level handshake).
// Latency : n/a (wiring only).
// Backpr. : requester holds in_ready and operands until out_ready, then drops in_ready.
// Ports   : in_ready, a_m, b_m (requester -> divider);
//           out_ready, quotient_out, sticky_out, dz_out, ovf_out (divider -> requester).
interface quotient_calc_if;
    import fpu_div_pkg::*;

    logic          in_ready;
    logic [MW-1:0] a_m;
    logic [MW-1:0] b_m;
    logic          out_ready;
    logic [QW-1:0] quotient_out;
    logic          sticky_out;
    logic          dz_out;
    logic          ovf_out;

    modport master (
        output in_ready, a_m, b_m,
        input  out_ready, quotient_out, sticky_out, dz_out, ovf_out
    );

    modport slave (
        input  in_ready, a_m, b_m,
        output out_ready, quotient_out, sticky_out, dz_out, ovf_out
    );

endinterface

// File: rtl/div_step.sv
// Purpose : one restoring-division step: trial subtract, select, shift left.
// Latency : combinational.
// Backpr. : none.
// Ports   : rem/b in; q_bit and next_rem (already shifted) out.
module div_step
    import fpu_div_pkg::*;
(
    input  logic [MW:0]   rem,
    input  logic [MW-1:0] b,
    output logic          q_bit,
    output logic [MW:0]   next_rem
);

    logic [MW:0] diff;
    logic [MW:0] sel;

    always_comb begin
        diff     = rem - {1'b0, b};
        q_bit    = (rem >= {1'b0, b});
        sel      = q_bit ? diff : rem;
        // sel < b after the step, so its top bit is always 0 and drops out of the shift
        next_rem = sel << 1;
    end

endmodule

// File: rtl/quotient_calc.sv
// Purpose : sequential radix-2 restoring mantissa divider with sticky, div-by-zero and overflow flags.
// Latency : QW cycles from capture on the normal path, 1 cycle on the saturate path.
// Backpr. : level handshake; result held with out_ready high until in_ready drops.
// Ports   : clk, rst_n (async, active-low); io = quotient_calc_if.slave bundle.
module quotient_calc
    import fpu_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    quotient_calc_if.slave  io
);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW:0]   rem_q, rem_d;
    logic [MW-1:0] b_q, b_d;
    logic [QW-2:0] quot_q, quot_d;     // first QW-1 bits; the last bit joins at completion
    logic          sat_q, sat_d;       // operands broke a < 2b (covers b == 0)
    logic [QW-1:0] q_out_q, q_out_d;
    logic          sticky_q, sticky_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;

    logic          step_bit;
    logic [MW:0]   step_rem;
    logic          last_step;

    div_step u_step (
        .rem      (rem_q),
        .b        (b_q),
        .q_bit    (step_bit),
        .next_rem (step_rem)
    );

    assign last_step = (cnt_q == CW'(QW - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            b_q      <= '0;
            quot_q   <= '0;
            sat_q    <= 1'b0;
            q_out_q  <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            b_q      <= b_d;
            quot_q   <= quot_d;
            sat_q    <= sat_d;
            q_out_q  <= q_out_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_ready)          state_d = DIVIDE;
            DIVIDE:  if (sat_q || last_step)   state_d = DONE;
            DONE:    if (!io.in_ready)         state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Datapath: capture, iterate, publish
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        b_d      = b_q;
        quot_d   = quot_q;
        sat_d    = sat_q;
        q_out_d  = q_out_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (io.in_ready) begin
                    b_d    = io.b_m;
                    rem_d  = {1'b0, io.a_m};
                    cnt_d  = '0;
                    quot_d = '0;
                    // a >= 2b would need a second integer quotient bit
                    sat_d  = ({1'b0, io.a_m} >= {io.b_m, 1'b0});
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            DIVIDE: begin
                if (sat_q) begin
                    // saturated result is published one edge after capture
                    q_out_d  = '1;
                    sticky_d = 1'b0;
                    ovf_d    = 1'b1;
                    dz_d     = (b_q == '0);
                end else begin
                    rem_d  = step_rem;
                    quot_d = {quot_q[QW-3:0], step_bit};
                    cnt_d  = cnt_q + CW'(1);
                    if (last_step) begin
                        q_out_d  = {quot_q, step_bit};
                        sticky_d = (step_rem != '0);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        io.out_ready    = (state_q == DONE);
        io.quotient_out = q_out_q;
        io.sticky_out   = sticky_q;
        io.dz_out       = dz_q;
        io.ovf_out      = ovf_q;
    end

endmodule

// File: tb/tb_quotient_calc.sv
// Purpose : randomized self-checking bench for quotient_calc against an arithmetic reference.
// Latency : expects QW cycles normal, 1 cycle saturate, out_ready drop one edge after in_ready falls.
// Backpr. : bench holds in_ready until out_ready, then releases it.
module tb_quotient_calc;
    import fpu_div_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    quotient_calc_if dut_if ();

    quotient_calc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: quotient = floor(a * 2^(QW-1) / b), saturate when a >= 2b.
    task automatic model(input logic [23:0] a, input logic [23:0] b,
                         output logic [63:0] q, output logic s,
                         output logic dz, output logic ovf, output int lat);
        longint unsigned num;
        num = longint'(a) << (QW - 1);
        if (b == 0 || longint'(a) >= 2 * longint'(b)) begin
            q = 64'h7FF_FFFF; s = 1'b0; ovf = 1'b1; dz = (b == 0); lat = 1;
        end else begin
            q = num / longint'(b); s = ((num % longint'(b)) != 0);
            ovf = 1'b0; dz = 1'b0; lat = QW;
        end
    endtask

    // Counts falling edges since the capture edge until out_ready is seen.
    task automatic wait_done(input bit scramble, output int lat);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (scramble) begin
                dut_if.a_m = 24'($urandom);
                dut_if.b_m = 24'($urandom);
            end
            if (dut_if.out_ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [23:0] a, input logic [23:0] b,
                                input int lat);
        logic [63:0] eq;
        logic es, edz, eovf;
        int elat;
        model(a, b, eq, es, edz, eovf, elat);
        chk({tag, "_seen"}, 64'(lat >= 0), 64'd1);
        if (lat >= 0) begin
            chk({tag, "_lat"}, 64'(lat), 64'(elat));
            chk({tag, "_q"}, 64'(dut_if.quotient_out), eq);
            chk({tag, "_sticky"}, 64'(dut_if.sticky_out), 64'(es));
            chk({tag, "_dz"}, 64'(dut_if.dz_out), 64'(edz));
            chk({tag, "_ovf"}, 64'(dut_if.ovf_out), 64'(eovf));
        end
    endtask

    task automatic run_txn(input string tag, input logic [23:0] a, input logic [23:0] b,
                           input bit scramble, input int hold);
        int lat;
        logic [26:0] qheld;
        @(negedge clk);
        dut_if.in_ready = 1'b1;
        dut_if.a_m      = a;
        dut_if.b_m      = b;
        wait_done(scramble, lat);
        check_result(tag, a, b, lat);
        qheld = dut_if.quotient_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_rdy"}, 64'(dut_if.out_ready), 64'd1);
            chk({tag, "_hold_q"}, 64'(dut_if.quotient_out), 64'(qheld));
        end
        dut_if.in_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_drop"}, 64'(dut_if.out_ready), 64'd0);
        chk({tag, "_keep_q"}, 64'(dut_if.quotient_out), 64'(qheld));
    endtask

    initial begin
        int lat;
        int mode;
        logic [23:0] ra, rb;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        dut_if.in_ready = 1'b0;
        dut_if.a_m = '0;
        dut_if.b_m = '0;
        #1;
        chk("rst_rdy", 64'(dut_if.out_ready), 64'd0);
        chk("rst_q", 64'(dut_if.quotient_out), 64'd0);
        chk("rst_flags", 64'({dut_if.sticky_out, dut_if.dz_out, dut_if.ovf_out}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_txn("one", 24'h800000, 24'h800000, 1'b0, 0);
        run_txn("onehalf", 24'hC00000, 24'h800000, 1'b1, 0);
        run_txn("twothird", 24'h800000, 24'hC00000, 1'b0, 0);
        run_txn("max", 24'hFFFFFF, 24'h800000, 1'b0, 0);
        run_txn("divzero", 24'h800000, 24'h000000, 1'b0, 0);
        run_txn("ovf", 24'hFFFFFF, 24'h7FFFFF, 1'b1, 0);
        run_txn("edge", 24'hFFFFFD, 24'h7FFFFF, 1'b0, 0);
        run_txn("hold", 24'hA5A5A5, 24'hC3C3C3, 1'b0, 50);

        // Reset in the middle of a divide, with a new request already pending on release.
        @(negedge clk);
        dut_if.in_ready = 1'b1;
        dut_if.a_m = 24'hC00000;
        dut_if.b_m = 24'h800000;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", 64'(dut_if.out_ready), 64'd0);
        chk("abort_q", 64'(dut_if.quotient_out), 64'd0);
        chk("abort_flags", 64'({dut_if.sticky_out, dut_if.dz_out, dut_if.ovf_out}), 64'd0);
        dut_if.a_m = 24'h800000;
        dut_if.b_m = 24'hC00000;
        @(negedge clk);
        chk("abort_hold", 64'(dut_if.out_ready), 64'd0);
        rst_n = 1'b1;
        wait_done(1'b0, lat);
        check_result("after_rst", 24'h800000, 24'hC00000, lat);
        dut_if.in_ready = 1'b0;
        @(negedge clk);
        chk("after_rst_drop", 64'(dut_if.out_ready), 64'd0);

        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 3);
            ra = 24'($urandom);
            rb = 24'($urandom);
            case (mode)
                0: begin ra[23] = 1'b1; rb[23] = 1'b1; end
                1: ;
                2: rb = '0;
                default: begin ra[23] = 1'b1; rb = 24'($urandom_range(1, 255)); end
            endcase
            run_txn($sformatf("rnd%0d", t), ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
